corner_extent_tracker: RTL and testbench

Per-frame extent accumulator that sits directly downstream of the green-pixel/corner detector stage. It consumes the per-pixel detection flag and pixel coordinates and tracks four extreme detected pixels: topmost, bottommost, leftmost and rightmost. It also counts detected pixels. At each frame boundary it publishes the four extremes, the count and a found flag to the corner-selection logic with a one-cycle strobe.

---
 rtl/corner_extent_tracker.sv | 180 ++++++++++++++++++
 tb/tb_corner_extent_tracker.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/corner_extent_tracker.sv
// Per-frame extent accumulator: tracks topmost/bottommost/leftmost/rightmost detected
// pixels and a saturating pixel count, publishing them with a one-cycle strobe per frame.
module corner_extent_tracker #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned MIN_PIXELS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pixel_valid,
    input  logic        corner_detected,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    output logic [9:0]  top_x,
    output logic [9:0]  top_y,
    output logic [9:0]  bottom_x,
    output logic [9:0]  bottom_y,
    output logic [9:0]  left_x,
    output logic [9:0]  left_y,
    output logic [9:0]  right_x,
    output logic [9:0]  right_y,
    output logic [18:0] pixel_count,
    output logic        found,
    output logic        result_valid
);

    localparam int unsigned CW = 10;
    localparam int unsigned NW = 19;
    localparam logic [CW-1:0] COORD_MAX = '1;
    localparam logic [NW-1:0] COUNT_MAX = '1;

    typedef enum logic {SYNC, ACCUM} state_t;

    state_t state, state_next;
    logic   publish_c, reload_c, take_c;
    logic   in_range_c, boundary_c;

    // Accumulators: min_y/max_y/min_x/max_x double as the published extreme coordinate.
    logic [CW-1:0] min_y, top_px, max_y, bot_px, min_x, left_py, max_x, right_py;
    logic [NW-1:0] count;

    logic [CW-1:0] b_min_y, b_top_px, b_max_y, b_bot_px, b_min_x, b_left_py, b_max_x, b_right_py;
    logic [NW-1:0] b_count;
    logic [CW-1:0] n_min_y, n_top_px, n_max_y, n_bot_px, n_min_x, n_left_py, n_max_x, n_right_py;
    logic [NW-1:0] n_count;

    assign in_range_c = pixel_valid && (x < CW'(H_ACTIVE)) && (y < CW'(V_ACTIVE));
    assign boundary_c = in_range_c && (x == '0) && (y == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SYNC;
        else        state <= state_next;
    end

    // Frame sequencing: SYNC waits for the first boundary, ACCUM publishes on each one.
    always_comb begin
        state_next = state;
        publish_c  = 1'b0;
        reload_c   = 1'b0;
        take_c     = 1'b0;
        case (state)
            SYNC: begin
                if (boundary_c) begin
                    state_next = ACCUM;
                    reload_c   = 1'b1;
                    take_c     = corner_detected;
                end
            end
            ACCUM: begin
                if (boundary_c) begin
                    publish_c = 1'b1;
                    reload_c  = 1'b1;
                    take_c    = corner_detected;
                end else if (in_range_c && corner_detected) begin
                    take_c = 1'b1;
                end
            end
            default: state_next = SYNC;
        endcase
    end

    // Next accumulator values: start from cleared or current, then fold in the pixel.
    always_comb begin
        b_min_y    = reload_c ? COORD_MAX : min_y;
        b_top_px   = reload_c ? '0 : top_px;
        b_max_y    = reload_c ? '0 : max_y;
        b_bot_px   = reload_c ? '0 : bot_px;
        b_min_x    = reload_c ? COORD_MAX : min_x;
        b_left_py  = reload_c ? '0 : left_py;
        b_max_x    = reload_c ? '0 : max_x;
        b_right_py = reload_c ? '0 : right_py;
        b_count    = reload_c ? '0 : count;

        n_min_y    = b_min_y;
        n_top_px   = b_top_px;
        n_max_y    = b_max_y;
        n_bot_px   = b_bot_px;
        n_min_x    = b_min_x;
        n_left_py  = b_left_py;
        n_max_x    = b_max_x;
        n_right_py = b_right_py;
        n_count    = b_count;

        if (take_c) begin
            if (b_count != COUNT_MAX) n_count = b_count + NW'(1);
            if (y < b_min_y) begin
                n_min_y  = y;
                n_top_px = x;
            end
            if ((y > b_max_y) || (b_count == '0)) begin
                n_max_y  = y;
                n_bot_px = x;
            end
            if (x < b_min_x) begin
                n_min_x   = x;
                n_left_py = y;
            end
            if ((x > b_max_x) || (b_count == '0)) begin
                n_max_x    = x;
                n_right_py = y;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_y    <= COORD_MAX;
            top_px   <= '0;
            max_y    <= '0;
            bot_px   <= '0;
            min_x    <= COORD_MAX;
            left_py  <= '0;
            max_x    <= '0;
            right_py <= '0;
            count    <= '0;
        end else if (reload_c || take_c) begin
            min_y    <= n_min_y;
            top_px   <= n_top_px;
            max_y    <= n_max_y;
            bot_px   <= n_bot_px;
            min_x    <= n_min_x;
            left_py  <= n_left_py;
            max_x    <= n_max_x;
            right_py <= n_right_py;
            count    <= n_count;
        end
    end

    // Published results: captured from the finished frame on a boundary, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_x        <= '0;
            top_y        <= '0;
            bottom_x     <= '0;
            bottom_y     <= '0;
            left_x       <= '0;
            left_y       <= '0;
            right_x      <= '0;
            right_y      <= '0;
            pixel_count  <= '0;
            found        <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= publish_c;
            if (publish_c) begin
                top_x       <= top_px;
                top_y       <= min_y;
                bottom_x    <= bot_px;
                bottom_y    <= max_y;
                left_x      <= min_x;
                left_y      <= left_py;
                right_x     <= max_x;
                right_y     <= right_py;
                pixel_count <= count;
                found       <= (count >= NW'(MIN_PIXELS));
            end
        end
    end

endmodule

// File: tb/tb_corner_extent_tracker.sv
// Self-checking bench for corner_extent_tracker: directed scenarios plus randomized
// pixel streams compared against a frame-list reference model.
module tb_corner_extent_tracker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pixel_valid, corner_detected;
    logic [9:0]  x, y;
    logic [9:0]  top_x, top_y, bottom_x, bottom_y, left_x, left_y, right_x, right_y;
    logic [18:0] pixel_count;
    logic        found, result_valid;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference model: list of detected pixels of the frame in progress.
    int          qx[$];
    int          qy[$];
    bit          synced;
    logic [99:0] exp_out;

    corner_extent_tracker dut (
        .clk(clk), .rst_n(rst_n), .pixel_valid(pixel_valid),
        .corner_detected(corner_detected), .x(x), .y(y),
        .top_x(top_x), .top_y(top_y), .bottom_x(bottom_x), .bottom_y(bottom_y),
        .left_x(left_x), .left_y(left_y), .right_x(right_x), .right_y(right_y),
        .pixel_count(pixel_count), .found(found), .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [99:0] dut_outs();
        return {top_x, top_y, bottom_x, bottom_y, left_x, left_y,
                right_x, right_y, pixel_count, found};
    endfunction

    // Extremes of the pixel list; ties go to the earliest pixel in arrival order.
    function automatic logic [99:0] frame_summary();
        int n = qx.size();
        int mn_y = 1023, mx_y = 0, mn_x = 1023, mx_x = 0;
        int it = -1, ib = -1, il = -1, ir = -1;
        int cnt;
        logic [9:0] tx, ty, bx, by, lx, ly, rx, ry;
        for (int i = 0; i < n; i++) begin
            if (qy[i] < mn_y) mn_y = qy[i];
            if (qy[i] > mx_y) mx_y = qy[i];
            if (qx[i] < mn_x) mn_x = qx[i];
            if (qx[i] > mx_x) mx_x = qx[i];
        end
        for (int i = n - 1; i >= 0; i--) begin
            if (qy[i] == mn_y) it = i;
            if (qy[i] == mx_y) ib = i;
            if (qx[i] == mn_x) il = i;
            if (qx[i] == mx_x) ir = i;
        end
        if (n == 0) begin
            tx = 10'd0; ty = 10'h3FF; bx = 10'd0; by = 10'd0;
            lx = 10'h3FF; ly = 10'd0; rx = 10'd0; ry = 10'd0;
        end else begin
            tx = 10'(qx[it]); ty = 10'(qy[it]);
            bx = 10'(qx[ib]); by = 10'(qy[ib]);
            lx = 10'(qx[il]); ly = 10'(qy[il]);
            rx = 10'(qx[ir]); ry = 10'(qy[ir]);
        end
        cnt = (n > 524287) ? 524287 : n;
        return {tx, ty, bx, by, lx, ly, rx, ry, 19'(cnt), 1'(cnt >= 16)};
    endfunction

    task automatic model_reset();
        qx.delete();
        qy.delete();
        synced  = 1'b0;
        exp_out = '0;
    endtask

    // One pixel cycle: drive on the falling edge, check just after the rising edge.
    task automatic drive(input logic v, input logic det, input int px, input int py);
        bit   in_range, boundary;
        logic exp_rv;
        @(negedge clk);
        pixel_valid     = v;
        corner_detected = det;
        x               = 10'(px);
        y               = 10'(py);
        in_range = v && (px < 640) && (py < 480);
        boundary = in_range && (px == 0) && (py == 0);
        exp_rv   = 1'b0;
        if (boundary) begin
            if (synced) begin
                exp_out = frame_summary();
                exp_rv  = 1'b1;
            end
            synced = 1'b1;
            qx.delete();
            qy.delete();
            if (det) begin
                qx.push_back(0);
                qy.push_back(0);
            end
        end else if (synced && in_range && det) begin
            qx.push_back(px);
            qy.push_back(py);
        end
        @(posedge clk);
        #1;
        check("result_valid", 128'(result_valid), 128'(exp_rv));
        check("outputs", 128'(dut_outs()), 128'(exp_out));
    endtask

    initial begin
        rst_n = 1'b0;
        pixel_valid = 1'b0;
        corner_detected = 1'b0;
        x = '0;
        y = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 128'(dut_outs()), 128'(0));
        check("reset_rv", 128'(result_valid), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Partial frame after reset is discarded.
        drive(1, 1, 50, 60);
        drive(1, 1, 70, 20);
        drive(1, 1, 10, 300);

        // Diamond.
        drive(1, 0, 0, 0);
        drive(1, 1, 100, 50);
        drive(1, 1, 60, 80);
        drive(1, 1, 140, 80);
        drive(1, 1, 100, 110);
        drive(1, 0, 0, 0);
        check("diamond_top", 128'({top_x, top_y}), 128'({10'd100, 10'd50}));
        check("diamond_left", 128'({left_x, left_y}), 128'({10'd60, 10'd80}));
        check("diamond_right", 128'({right_x, right_y}), 128'({10'd140, 10'd80}));
        check("diamond_bottom", 128'({bottom_x, bottom_y}), 128'({10'd100, 10'd110}));
        check("diamond_count", 128'({pixel_count, found}), 128'({19'd4, 1'b0}));

        // Single row: ties and found threshold.
        for (int i = 300; i < 320; i++) drive(1, 1, i, 200);
        drive(1, 0, 0, 0);
        check("row_top", 128'({top_x, top_y}), 128'({10'd300, 10'd200}));
        check("row_bottom", 128'({bottom_x, bottom_y}), 128'({10'd300, 10'd200}));
        check("row_left", 128'({left_x, left_y}), 128'({10'd300, 10'd200}));
        check("row_right", 128'({right_x, right_y}), 128'({10'd319, 10'd200}));
        check("row_count", 128'({pixel_count, found}), 128'({19'd20, 1'b1}));

        // Empty frame with undetected and out-of-range pixels.
        drive(1, 0, 30, 40);
        drive(0, 1, 31, 40);
        drive(1, 1, 700, 10);
        drive(1, 1, 10, 500);
        drive(1, 1, 640, 0);
        drive(1, 0, 0, 0);
        check("empty_count", 128'({pixel_count, found}), 128'({19'd0, 1'b0}));
        check("empty_top_y", 128'(top_y), 128'(10'h3FF));
        check("empty_left_x", 128'(left_x), 128'(10'h3FF));
        check("empty_bottom_y", 128'(bottom_y), 128'(10'd0));
        check("empty_right_x", 128'(right_x), 128'(10'd0));

        // Detected boundary pixel belongs to the following frame; back-to-back boundaries.
        drive(1, 1, 5, 5);
        drive(1, 1, 0, 0);
        check("pre_bnd_count", 128'(pixel_count), 128'(19'd1));
        check("pre_bnd_top", 128'({top_x, top_y}), 128'({10'd5, 10'd5}));
        drive(1, 0, 0, 0);
        check("bnd_count", 128'(pixel_count), 128'(19'd1));
        check("bnd_top", 128'({top_x, top_y}), 128'({10'd0, 10'd0}));
        check("bnd_left", 128'({left_x, left_y}), 128'({10'd0, 10'd0}));

        // Async reset mid-frame.
        drive(1, 1, 200, 200);
        drive(1, 1, 210, 100);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_outputs", 128'(dut_outs()), 128'(0));
        check("async_rv", 128'(result_valid), 128'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 1, 40, 40);
        drive(1, 1, 0, 0);
        drive(1, 1, 90, 30);
        drive(1, 1, 0, 0);

        // Randomized streams with clustered coordinates to provoke ties.
        for (int i = 0; i < 1500; i++) begin
            int r, px, py;
            logic v, det;
            r   = int'($urandom_range(0, 99));
            v   = ($urandom_range(0, 9) != 0);
            det = ($urandom_range(0, 3) != 0);
            if (r < 3) begin
                px = 0;
                py = 0;
            end else if (r < 50) begin
                px = int'($urandom_range(0, 15)) + 100;
                py = int'($urandom_range(0, 15)) + 100;
            end else if (r < 90) begin
                px = int'($urandom_range(0, 639));
                py = int'($urandom_range(0, 479));
            end else begin
                px = int'($urandom_range(0, 1023));
                py = int'($urandom_range(0, 1023));
            end
            drive(v, det, px, py);
        end
        drive(1, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
